// File: rtl/chess_pkg.sv
// Shared chess encodings: board geometry, piece codes, move status and executor states.
package chess_pkg;

  localparam int SQ_W = 6;
  localparam int PC_W = 5;

  localparam logic [PC_W-1:0] PC_EMPTY  = 5'd0;
  localparam logic [PC_W-1:0] WHITE_MAX = 5'd16;

  typedef enum logic [2:0] {
    ST_OK              = 3'd0,
    ST_ERR_EMPTY       = 3'd1,
    ST_ERR_SAME_SQ     = 3'd2,
    ST_ERR_OWN_CAPTURE = 3'd3,
    ST_ERR_WRONG_SIDE  = 3'd4
  } status_t;

  typedef enum logic [3:0] {
    S_IDLE,
    S_RD_SRC,
    S_WAIT_SRC,
    S_RD_DST,
    S_WAIT_DST,
    S_CHECK,
    S_WR_DST,
    S_WR_SRC,
    S_RESP
  } exec_state_t;

  // Codes above WHITE_MAX belong to black; callers pass the zero-extended piece code.
  function automatic logic is_black(input int unsigned code);
    return code > 32'(WHITE_MAX);
  endfunction

  function automatic logic is_occupied(input int unsigned code);
    return code != 32'(PC_EMPTY);
  endfunction

endpackage

// File: rtl/move_executor_if.sv
// Command, response and board-RAM signals of the move executor.
interface move_executor_if;

  logic                      cmd_valid;
  logic                      cmd_ready;
  logic [chess_pkg::SQ_W-1:0] cmd_src;
  logic [chess_pkg::SQ_W-1:0] cmd_dst;
  logic                      cmd_side;

  logic                      resp_valid;
  logic                      resp_ready;
  logic [2:0]                resp_status;
  logic [chess_pkg::PC_W-1:0] resp_piece;
  logic [chess_pkg::PC_W-1:0] resp_captured;

  logic                      mem_en;
  logic                      mem_rw;
  logic [chess_pkg::SQ_W-1:0] mem_adress;
  logic [chess_pkg::PC_W-1:0] mem_data_in;
  logic [chess_pkg::PC_W-1:0] mem_data_out;

  modport master (
    input  cmd_valid, cmd_src, cmd_dst, cmd_side, resp_ready, mem_data_out,
    output cmd_ready, resp_valid, resp_status, resp_piece, resp_captured,
           mem_en, mem_rw, mem_adress, mem_data_in
  );

  modport slave (
    output cmd_valid, cmd_src, cmd_dst, cmd_side, resp_ready, mem_data_out,
    input  cmd_ready, resp_valid, resp_status, resp_piece, resp_captured,
           mem_en, mem_rw, mem_adress, mem_data_in
  );

endinterface

// File: rtl/move_precheck.sv
// Combinational move sanity check: same square, empty source, wrong colour, own capture.
module move_precheck
  import chess_pkg::*;
(
  input  logic [SQ_W-1:0] src,
  input  logic [SQ_W-1:0] dst,
  input  logic            side,
  input  logic [PC_W-1:0] piece,
  input  logic [PC_W-1:0] captured,
  output status_t         status
);

  // First matching rule wins; the same-square test outranks occupancy.
  always_comb begin
    status = ST_OK;
    if (src == dst) begin
      status = ST_ERR_SAME_SQ;
    end else if (!is_occupied(32'(piece))) begin
      status = ST_ERR_EMPTY;
    end else if (is_black(32'(piece)) != side) begin
      status = ST_ERR_WRONG_SIDE;
    end else if (is_occupied(32'(captured)) && (is_black(32'(captured)) == side)) begin
      status = ST_ERR_OWN_CAPTURE;
    end
  end

endmodule

// File: rtl/move_executor.sv
// Executes one validated move on the board RAM: read src, read dst, check, write dst then clear src.
module move_executor
  import chess_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic            clk,
  input  logic            reset,
  move_executor_if.master bus
);

  localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);

  exec_state_t     state_reg, state_next;
  logic [1:0]      wait_cnt_reg, wait_cnt_next;
  logic [SQ_W-1:0] src_reg, src_next, dst_reg, dst_next;
  logic            side_reg, side_next;
  logic [PC_W-1:0] piece_reg, piece_next, captured_reg, captured_next;
  status_t         status_reg, status_next, check_status;
  logic            cmd_ready_reg, cmd_ready_next;
  logic            resp_valid_reg, resp_valid_next;
  logic            mem_en_reg, mem_en_next, mem_rw_reg, mem_rw_next;
  logic [SQ_W-1:0] mem_adress_reg, mem_adress_next;
  logic [PC_W-1:0] mem_data_in_reg, mem_data_in_next;

  move_precheck u_precheck (
    .src      (src_reg),
    .dst      (dst_reg),
    .side     (side_reg),
    .piece    (piece_reg),
    .captured (captured_reg),
    .status   (check_status)
  );

  always_comb begin
    state_next       = state_reg;
    wait_cnt_next    = wait_cnt_reg;
    src_next         = src_reg;
    dst_next         = dst_reg;
    side_next        = side_reg;
    piece_next       = piece_reg;
    captured_next    = captured_reg;
    status_next      = status_reg;
    mem_en_next      = 1'b0;
    mem_rw_next      = 1'b0;
    mem_adress_next  = mem_adress_reg;
    mem_data_in_next = mem_data_in_reg;

    case (state_reg)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          src_next   = bus.cmd_src;
          dst_next   = bus.cmd_dst;
          side_next  = bus.cmd_side;
          state_next = S_RD_SRC;
        end
      end
      S_RD_SRC: begin
        wait_cnt_next = WAIT_INIT;
        state_next    = S_WAIT_SRC;
      end
      S_WAIT_SRC: begin
        if (wait_cnt_reg == 2'd0) begin
          piece_next = bus.mem_data_out;
          state_next = S_RD_DST;
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end
      S_RD_DST: begin
        wait_cnt_next = WAIT_INIT;
        state_next    = S_WAIT_DST;
      end
      S_WAIT_DST: begin
        if (wait_cnt_reg == 2'd0) begin
          captured_next = bus.mem_data_out;
          state_next    = S_CHECK;
        end else begin
          wait_cnt_next = wait_cnt_reg - 2'd1;
        end
      end
      S_CHECK: begin
        status_next = check_status;
        state_next  = (check_status == ST_OK) ? S_WR_DST : S_RESP;
      end
      S_WR_DST: state_next = S_WR_SRC;
      S_WR_SRC: state_next = S_RESP;
      S_RESP: begin
        if (bus.resp_ready) begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase

    // Output flops are loaded with the value belonging to the state being entered.
    cmd_ready_next  = (state_next == S_IDLE);
    resp_valid_next = (state_next == S_RESP);
    case (state_next)
      S_RD_SRC: begin
        mem_en_next     = 1'b1;
        mem_adress_next = src_next;
      end
      S_RD_DST: begin
        mem_en_next     = 1'b1;
        mem_adress_next = dst_reg;
      end
      S_WR_DST: begin
        mem_en_next      = 1'b1;
        mem_rw_next      = 1'b1;
        mem_adress_next  = dst_reg;
        mem_data_in_next = piece_reg;
      end
      S_WR_SRC: begin
        mem_en_next      = 1'b1;
        mem_rw_next      = 1'b1;
        mem_adress_next  = src_reg;
        mem_data_in_next = PC_EMPTY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg       <= S_IDLE;
      wait_cnt_reg    <= 2'd0;
      src_reg         <= '0;
      dst_reg         <= '0;
      side_reg        <= 1'b0;
      piece_reg       <= '0;
      captured_reg    <= '0;
      status_reg      <= ST_OK;
      cmd_ready_reg   <= 1'b1;
      resp_valid_reg  <= 1'b0;
      mem_en_reg      <= 1'b0;
      mem_rw_reg      <= 1'b0;
      mem_adress_reg  <= '0;
      mem_data_in_reg <= '0;
    end else begin
      state_reg       <= state_next;
      wait_cnt_reg    <= wait_cnt_next;
      src_reg         <= src_next;
      dst_reg         <= dst_next;
      side_reg        <= side_next;
      piece_reg       <= piece_next;
      captured_reg    <= captured_next;
      status_reg      <= status_next;
      cmd_ready_reg   <= cmd_ready_next;
      resp_valid_reg  <= resp_valid_next;
      mem_en_reg      <= mem_en_next;
      mem_rw_reg      <= mem_rw_next;
      mem_adress_reg  <= mem_adress_next;
      mem_data_in_reg <= mem_data_in_next;
    end
  end

  assign bus.cmd_ready     = cmd_ready_reg;
  assign bus.resp_valid    = resp_valid_reg;
  assign bus.resp_status   = status_reg;
  assign bus.resp_piece    = piece_reg;
  assign bus.resp_captured = captured_reg;
  assign bus.mem_en        = mem_en_reg;
  assign bus.mem_rw        = mem_rw_reg;
  assign bus.mem_adress    = mem_adress_reg;
  assign bus.mem_data_in   = mem_data_in_reg;

endmodule

// File: doc/move_executor.md
Name: move_executor

Overview:
- Bus initiator for the 64x5 chess board RAM; the RAM is the responder on the same port.
- Accepts one move command (source square, destination square, side to move) and reads both squares.
- Validates occupancy and colour, then writes the piece to the destination and clears the source.
- Returns a status and the captured piece code. Rule engines such as rook legality sit upstream and issue commands here.

Parameters:
- RD_LAT, 1, RAM read latency in cycles from the read-issue cycle to valid mem_data_out (legal 1..3).
- SQ_W, 6, square index width. Square 0 = a1, 7 = h1, 63 = h8.
- PC_W, 5, piece code width. 0 = empty, 1..16 = white, 17..31 = black.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  move command valid
- cmd_ready  out  1  executor idle, can accept a command
- cmd_src  in  SQ_W  source square
- cmd_dst  in  SQ_W  destination square
- cmd_side  in  1  side to move: 0 = white, 1 = black
- resp_valid  out  1  result valid; held until accepted
- resp_ready  in  1  result consumer ready
- resp_status  out  3  0 OK, 1 ERR_EMPTY, 2 ERR_SAME_SQ, 3 ERR_OWN_CAPTURE, 4 ERR_WRONG_SIDE
- resp_piece  out  PC_W  piece code read from the source square
- resp_captured  out  PC_W  piece code read from the destination (0 if the destination was empty)
- mem_en  out  1  RAM enable, registered
- mem_rw  out  1  1 = write, 0 = read, registered
- mem_adress  out  SQ_W  RAM address, registered
- mem_data_in  out  PC_W  RAM write data, registered
- mem_data_out  in  PC_W  RAM read data

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- Reset values:
  - state = IDLE.
  - cmd_ready = 1, resp_valid = 0.
  - resp_status, resp_piece, resp_captured = 0.
  - mem_en, mem_rw, mem_adress, mem_data_in = 0.
- All outputs are flops. A mem_* value "in state X" means it is visible during the cycle spent in X.
- Handshake:
  - A command is accepted on a clk edge where cmd_valid & cmd_ready; src, dst and side are latched then.
  - cmd_ready = 1 only in IDLE.
  - A response is accepted on an edge where resp_valid & resp_ready.
- FSM (one cycle per state unless stated):
  - IDLE -> RD_SRC on accept.
  - RD_SRC: mem_en = 1, rw = 0, adress = src. Next state WAIT_SRC.
  - WAIT_SRC: RD_LAT cycles, mem_en = 0. mem_data_out is captured into the piece register on the last cycle. Next state RD_DST.
  - RD_DST / WAIT_DST: same as RD_SRC / WAIT_SRC with dst; the value is captured into the captured register.
  - CHECK: no RAM access. Status is set by the first matching rule, in this priority order:
    - src == dst -> ERR_SAME_SQ
    - piece == 0 -> ERR_EMPTY
    - colour(piece) != side -> ERR_WRONG_SIDE
    - captured != 0 and colour(captured) == side -> ERR_OWN_CAPTURE
    - otherwise OK
    - OK -> WR_DST; any error -> RESP.
  - WR_DST: mem_en = 1, rw = 1, adress = dst, data_in = piece. Next state WR_SRC.
  - WR_SRC: mem_en = 1, rw = 1, adress = src, data_in = 0. Next state RESP.
  - RESP: resp_valid = 1; resp_status, resp_piece and resp_captured are stable. On resp_ready -> IDLE.
- Latency (RD_LAT = 1, accept edge = T0):
  - RD_SRC at T1, WAIT_SRC T2, RD_DST T3, WAIT_DST T4, CHECK T5.
  - OK path: WR_DST T6, WR_SRC T7, resp_valid from T8.
  - Error path: resp_valid from T6.
- Error paths never assert mem_en with rw = 1.
- Exactly two writes occur per OK move, destination first, then source.
- Captured-piece reporting: resp_captured is the destination's prior contents even on error. It is the value read from the RAM, not a value inferred by the executor.
- Square decode: a mem_adress of 0..63 maps directly, with no offset.
- Reset mid-operation:
  - Reset forces IDLE and clears mem_en on the same edge; no further RAM accesses follow.
  - A write already presented in the cycle of reset completes in the RAM.
  - The board may be left half-updated. Recovery is the upstream's responsibility.
- Simultaneous events:
  - In RESP, a new cmd_valid is ignored; cmd_ready = 0 until IDLE is reached.
  - No back-to-back accept on the resp-accept edge. The first accept is possible one cycle later.
- mem_data_out is sampled only in the final WAIT cycle; it is ignored at all other times.

Decomposition:
- chess_pkg holds:
  - SQ_W and PC_W.
  - PC_EMPTY = 0 and WHITE_MAX = 16.
  - function is_black(code) = (code >= 17), and the occupancy test (code != 0).
  - Status enum: OK, ERR_EMPTY, ERR_SAME_SQ, ERR_OWN_CAPTURE, ERR_WRONG_SIDE.
  - Executor state enum.
- One combinational sub-module, move_precheck: inputs src, dst, side, piece, captured; output status. It is reusable by future legality blocks.

Test Plan:
- Board RAM model at start position, RD_LAT = 1. Command e2 -> e4 (src 12, dst 28, side 0).
  - Required: OK, piece 5, captured 0.
  - Writes: [28] = 5 at T6, then [12] = 0 at T7. resp_valid at T8.
- Command src 28, dst 36, side 0 on the start board.
  - Required: ERR_EMPTY, piece 0, resp_valid at T6, zero writes.
- Command a1 -> a2 (src 0, dst 8, side 0).
  - Required: ERR_OWN_CAPTURE, piece 13, captured 1, no writes.
- Black pawn c7 -> c6 (src 50, dst 42) with side 0.
  - Required: ERR_WRONG_SIDE.
- Command src = dst = 12.
  - Required: ERR_SAME_SQ, taking precedence over the occupancy checks.
- Capture: preload [28] = 20 and [21] = 6. Command src 21, dst 28, side 0.
  - Required: OK, captured 20, [28] = 6, [21] = 0.
- Backpressure with resp_ready held low for 5 cycles.
  - Required: resp_valid and data stable, cmd_ready = 0 throughout.
- Same backpressure test rerun with RD_LAT = 3.
  - Required: resp_valid on the OK path at T12.
- Reset asserted in WAIT_DST.
  - Required: next cycle IDLE, cmd_ready = 1, no writes ever issued.
